// File: rtl/latch_wr_sequencer.sv
// latch_wr_sequencer: round-robin arbiter and SETUP -> OPEN -> HOLD write
// sequencer for one shared transparent D-latch word. It is the only driver of
// the latch en/din, and din is guaranteed stable around every en edge.
// Optional feature macro: LATCH_READBACK_EN adds latch_q readback and a sticky
// wr_err flag that is set when the latch output disagrees with din during HOLD.
//
// state | meaning
// IDLE  | no write in progress, waiting for any req
// SETUP | winner data on latch_din, latch_en low for one cycle
// OPEN  | latch_en high for OPEN_CYC cycles
// HOLD  | latch_en low, din unchanged, done pulse, arbitrate the next writer
module latch_wr_sequencer #(
  parameter int NUM_REQ  = 4,
  parameter int DW       = 8,
  parameter int OPEN_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic                  latch_en,
  output logic [DW-1:0]         latch_din
`ifdef LATCH_READBACK_EN
  ,
  input  logic [DW-1:0]         latch_q,
  output logic                  wr_err
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_OPEN  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]         state;
  logic [PW-1:0]      ptr;
  logic [CW-1:0]      open_cnt;

  logic [NUM_REQ-1:0] arb_req;
  logic               arb_found;
  logic [PW-1:0]      arb_idx;
  logic [PW-1:0]      arb_next_ptr;
  logic [NUM_REQ-1:0] arb_onehot;
  logic [DW-1:0]      arb_data;

  // Round-robin pick: first request at or after ptr, wrapping. The current
  // writer is masked so HOLD never re-grants the requester it just served.
  always_comb begin
    arb_req   = req & ~gnt;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (int'(ptr) + i) % NUM_REQ;
      if (!arb_found && arb_req[k]) begin
        arb_found = 1'b1;
        arb_idx   = PW'(k);
      end
    end
    arb_next_ptr = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + PW'(1);
    arb_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
    // Only the winner's lane is selected, so unknowns elsewhere stay out.
    arb_data     = wdata[int'(arb_idx)*DW +: DW];
  end

  // Sequencer FSM; every output is a register so the latch sees no glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      latch_en  <= 1'b0;
      latch_din <= '0;
      ptr       <= '0;
      open_cnt  <= '0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_found) begin
            state     <= ST_SETUP;
            gnt       <= arb_onehot;
            latch_din <= arb_data;
            ptr       <= arb_next_ptr;
            busy      <= 1'b1;
          end
        end
        ST_SETUP: begin
          state    <= ST_OPEN;
          latch_en <= 1'b1;
          open_cnt <= CW'(OPEN_CYC - 1);
        end
        ST_OPEN: begin
          if (open_cnt == '0) begin
            state    <= ST_HOLD;
            latch_en <= 1'b0;
            done     <= gnt;
          end else begin
            open_cnt <= open_cnt - CW'(1);
          end
        end
        ST_HOLD: begin
          // Back-to-back handoff goes straight to SETUP with no IDLE bubble.
          if (arb_found) begin
            state     <= ST_SETUP;
            gnt       <= arb_onehot;
            latch_din <= arb_data;
            ptr       <= arb_next_ptr;
          end else begin
            state <= ST_IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          gnt      <= '0;
          busy     <= 1'b0;
          latch_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef LATCH_READBACK_EN
  // Sticky readback check: by HOLD the latch must hold exactly what was written.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else if (state == ST_HOLD && latch_q != latch_din) begin
      wr_err <= 1'b1;
    end
  end
`endif

endmodule
